// File: rtl/tm_multiclass_vote.sv
// tm_multiclass_vote -- multi-class clause vote and argmax stage.
// Captures one frame of positive/negative clause bits for NUM_CLASSES classes,
// sums one class per cycle, and returns per-class decisions plus the argmax
// class and its sum over a valid/ready handshake.
// Optional feature macro: TM_CLAMP_EN (saturate each class sum to +/-THRESH).
module tm_multiclass_vote #(
   parameter int NUM_CLASSES = 2,
   parameter int CL_PER_POL  = 2,
   parameter int THRESH      = 2,
   localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   localparam int SUM_W      = $clog2(CL_PER_POL + 1) + 1,
   localparam int NB         = NUM_CLASSES * CL_PER_POL
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NB-1:0]           pos_clause,
   input  logic [NB-1:0]           neg_clause,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CLS_W-1:0]        out_class,
   output logic signed [SUM_W-1:0] out_sum,
   output logic [NUM_CLASSES-1:0]  decision
);

   localparam int CNT_W = $clog2(CL_PER_POL + 1);

`ifdef TM_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   localparam logic signed [SUM_W-1:0] THR_P    = SUM_W'(THRESH);
   localparam logic signed [SUM_W-1:0] THR_N    = -THR_P;
   // Below any reachable class sum, so the first class always wins the compare.
   localparam logic signed [SUM_W-1:0] MOST_NEG = {1'b1, {(SUM_W-1){1'b0}}};
   localparam logic [CLS_W-1:0]        LAST_CLS = CLS_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SUM, ST_DONE} state_t;

   state_t                  state_q, state_d;
   logic [NB-1:0]           pos_q, pos_d;
   logic [NB-1:0]           neg_q, neg_d;
   logic [CLS_W-1:0]        ptr_q, ptr_d;
   logic [CLS_W-1:0]        best_cls_q, best_cls_d;
   logic signed [SUM_W-1:0] best_sum_q, best_sum_d;
   logic [NUM_CLASSES-1:0]  dec_q, dec_d;

   logic [CL_PER_POL-1:0]   pos_sel, neg_sel;
   logic signed [SUM_W-1:0] raw_s, class_s;

   function automatic logic [CNT_W-1:0] popcnt(input logic [CL_PER_POL-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < CL_PER_POL; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   assign pos_sel = pos_q[ptr_q*CL_PER_POL +: CL_PER_POL];
   assign neg_sel = neg_q[ptr_q*CL_PER_POL +: CL_PER_POL];
   assign raw_s   = $signed({1'b0, popcnt(pos_sel)}) - $signed({1'b0, popcnt(neg_sel)});

   // Optional saturation of the current class sum to +/-THRESH.
   always_comb begin
      class_s = raw_s;
      if (CLAMP_EN) begin
         if (raw_s > THR_P) begin
            class_s = THR_P;
         end else if (raw_s < THR_N) begin
            class_s = THR_N;
         end
      end
   end

   // Next-state logic: frame capture, per-class accumulation, result hold.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      neg_d      = neg_q;
      ptr_d      = ptr_q;
      best_cls_d = best_cls_q;
      best_sum_d = best_sum_q;
      dec_d      = dec_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               pos_d      = pos_clause;
               neg_d      = neg_clause;
               ptr_d      = '0;
               best_cls_d = '0;
               best_sum_d = MOST_NEG;
               dec_d      = '0;
               state_d    = ST_SUM;
            end
         end
         ST_SUM: begin
            dec_d[ptr_q] = ~class_s[SUM_W-1];
            // Strict compare: on a tie the lower class index is kept.
            if (class_s > best_sum_q) begin
               best_sum_d = class_s;
               best_cls_d = ptr_q;
            end
            if (ptr_q == LAST_CLS) begin
               state_d = ST_DONE;
            end else begin
               ptr_d = ptr_q + CLS_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pos_q      <= '0;
         neg_q      <= '0;
         ptr_q      <= '0;
         best_cls_q <= '0;
         best_sum_q <= '0;
         dec_q      <= '0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         neg_q      <= neg_d;
         ptr_q      <= ptr_d;
         best_cls_q <= best_cls_d;
         best_sum_q <= best_sum_d;
         dec_q      <= dec_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_class = best_cls_q;
   assign out_sum   = best_sum_q;
   assign decision  = dec_q;

endmodule

// File: tb/tb_tm_multiclass_vote.sv
// Directed bench for tm_multiclass_vote: a default instance (2 classes x 2 clauses)
// and a single-class instance with 4 clauses per polarity for the clamp case.
module tb_tm_multiclass_vote;

`ifdef TM_CLAMP_EN
   localparam int EXP_WIDE_SUM = 2;
`else
   localparam int EXP_WIDE_SUM = 4;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default instance
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [3:0]       pos, neg;
   logic [0:0]       out_class;
   logic signed [2:0] out_sum;
   logic [1:0]       decision;

   // single-class, 4 clauses per polarity
   logic             in_valid1, in_ready1, out_valid1, out_ready1;
   logic [3:0]       pos1, neg1;
   logic [0:0]       out_class1;
   logic signed [3:0] out_sum1;
   logic [0:0]       decision1;

   int n_pass  = 0;
   int n_total = 0;

   tm_multiclass_vote #(.NUM_CLASSES(2), .CL_PER_POL(2), .THRESH(2)) u0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .pos_clause(pos), .neg_clause(neg),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_sum(out_sum), .decision(decision)
   );

   tm_multiclass_vote #(.NUM_CLASSES(1), .CL_PER_POL(4), .THRESH(2)) u1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .pos_clause(pos1), .neg_clause(neg1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_class(out_class1), .out_sum(out_sum1), .decision(decision1)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Present a frame, then follow it to DONE without completing the handshake.
   task automatic start0(input string tag, input logic [3:0] p, input logic [3:0] n,
                         input int ecls, input int esum, input int edec);
      @(negedge clk);
      check({tag, ".in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      pos = p;
      neg = n;
      @(negedge clk);               // accept edge has passed: now in SUM
      in_valid = 1'b0;
      check({tag, ".busy"}, int'(in_ready), 0);
      check({tag, ".lat0"}, int'(out_valid), 0);
      @(negedge clk);
      check({tag, ".lat1"}, int'(out_valid), 0);
      @(negedge clk);               // third cycle counting the accept cycle
      check({tag, ".valid"}, int'(out_valid), 1);
      check({tag, ".class"}, int'(out_class), ecls);
      check({tag, ".sum"}, int'(out_sum), esum);
      check({tag, ".dec"}, int'(decision), edec);
   endtask

   task automatic frame0(input string tag, input logic [3:0] p, input logic [3:0] n,
                         input int ecls, input int esum, input int edec);
      start0(tag, p, n, ecls, esum, edec);
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, ".drop"}, int'(out_valid), 0);
      check({tag, ".hold"}, int'(out_sum), esum);
      out_ready = 1'b0;
   endtask

   initial begin : stim
      int seen;
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; pos = '0; neg = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; pos1 = '0; neg1 = '0;

      @(negedge clk);
      check("rst.in_ready", int'(in_ready), 1);
      check("rst.out_valid", int'(out_valid), 0);
      check("rst.out_sum", int'(out_sum), 0);
      check("rst.decision", int'(decision), 0);
      rst_n = 1'b1;

      // c0 = 2-0 = +2, c1 = 0-1 = -1
      frame0("basic", 4'b0011, 4'b0100, 0, 2, 2'b01);
      // c0 = 0-1 = -1, c1 = 2-0 = +2
      frame0("c1win", 4'b1100, 4'b0001, 1, 2, 2'b10);
      // tie c0 = c1 = +1, lowest index wins
      frame0("tie", 4'b0101, 4'b0000, 0, 1, 2'b11);
      // all negative: -2, -2
      frame0("allneg", 4'b0000, 4'b1111, 0, -2, 2'b00);

      // Backpressure: result held, new frame ignored while DONE
      start0("bp", 4'b1100, 4'b0001, 1, 2, 2'b10);
      in_valid = 1'b1;
      pos = 4'b1111;
      neg = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp.valid", int'(out_valid), 1);
         check("bp.in_ready", int'(in_ready), 0);
         check("bp.class", int'(out_class), 1);
         check("bp.sum", int'(out_sum), 2);
         check("bp.dec", int'(decision), 2'b10);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp.release_valid", int'(out_valid), 0);
      check("bp.release_ready", int'(in_ready), 1);
      @(negedge clk);               // frame 1111/0000 accepted on this edge
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp.next_valid", int'(out_valid), 1);
      check("bp.next_class", int'(out_class), 0);
      check("bp.next_sum", int'(out_sum), 2);
      check("bp.next_dec", int'(decision), 2'b11);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset asserted mid-SUM aborts the frame
      @(negedge clk);
      in_valid = 1'b1;
      pos = 4'b0011;
      neg = 4'b0100;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid.busy", int'(in_ready), 0);
      #1 rst_n = 1'b0;
      #1;
      check("mid.in_ready", int'(in_ready), 1);
      check("mid.out_valid", int'(out_valid), 0);
      check("mid.out_class", int'(out_class), 0);
      check("mid.out_sum", int'(out_sum), 0);
      check("mid.decision", int'(decision), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | int'(out_valid);
      end
      check("mid.no_result", seen, 0);

      // Single class, 4 clauses per polarity: raw sum +4, clamped to +2
      @(negedge clk);
      check("wide.in_ready", int'(in_ready1), 1);
      in_valid1 = 1'b1;
      pos1 = 4'b1111;
      neg1 = 4'b0000;
      @(negedge clk);
      in_valid1 = 1'b0;
      check("wide.lat0", int'(out_valid1), 0);
      @(negedge clk);
      check("wide.valid", int'(out_valid1), 1);
      check("wide.class", int'(out_class1), 0);
      check("wide.sum", int'(out_sum1), EXP_WIDE_SUM);
      check("wide.dec", int'(decision1), 1);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      check("wide.drop", int'(out_valid1), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
